// File: rtl/riscv_mem_pkg.sv
// Shared constants for the memory access stage: RV32I load/store funct3 codes,
// FSM state encoding and byte-enable patterns.
package riscv_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCESS   = 2'b01,
        ST_COMPLETE = 2'b10
    } state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_access_unit_if.sv
// Unified-memory port between the access stage (master) and memory (slave);
// a req/ack handshake with variable latency.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [3:0]              mem_be;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational lane logic: access legality, byte enables, store-data
// replication and sign/zero extension of the selected load lane.
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic        fetch,
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] write_data,
    input  logic [31:0] mem_rdata,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half out of the returned word.
    always_comb begin
        byte_s = mem_rdata[7:0];
        case (addr_lo)
            2'b00:   byte_s = mem_rdata[7:0];
            2'b01:   byte_s = mem_rdata[15:8];
            2'b10:   byte_s = mem_rdata[23:16];
            2'b11:   byte_s = mem_rdata[31:24];
            default: byte_s = mem_rdata[7:0];
        endcase
        half_s = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Fetch overrides write/funct3 and is always a word access.
    always_comb begin
        legal      = 1'b0;
        be         = BE_WORD;
        wdata      = write_data;
        load_value = mem_rdata;
        if (fetch) begin
            legal = (addr_lo == 2'b00);
        end else if (write) begin
            case (funct3)
                SB: begin
                    legal = 1'b1;
                    be    = BE_BYTE0 << addr_lo;
                    wdata = {4{write_data[7:0]}};
                end
                SH: begin
                    legal = ~addr_lo[0];
                    be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                    wdata = {2{write_data[15:0]}};
                end
                SW: begin
                    legal = (addr_lo == 2'b00);
                end
                default: begin
                    legal = 1'b0;
                    be    = BE_NONE;
                end
            endcase
        end else begin
            case (funct3)
                LB: begin
                    legal      = 1'b1;
                    load_value = {{24{byte_s[7]}}, byte_s};
                end
                LH: begin
                    legal      = ~addr_lo[0];
                    load_value = {{16{half_s[15]}}, half_s};
                end
                LW: begin
                    legal      = (addr_lo == 2'b00);
                end
                LBU: begin
                    legal      = 1'b1;
                    load_value = {24'h000000, byte_s};
                end
                LHU: begin
                    legal      = ~addr_lo[0];
                    load_value = {16'h0000, half_s};
                end
                default: begin
                    legal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle memory access stage: runs fetches, loads and stores over a single
// req/ack memory port and owns the instruction, old-PC and load-data registers.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fetch,
    input  logic                  write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] old_pc,
    output logic [DATA_WIDTH-1:0] read_data,
    mem_access_unit_if.master     mem
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                  state_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;
    logic [DATA_WIDTH-1:0]   instruction_r;
    logic [ADDR_WIDTH-1:0]   old_pc_r;
    logic [DATA_WIDTH-1:0]   read_data_r;
    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic [3:0]              mem_be_r;
    logic [CW-1:0]           cnt_r;
    logic                    fetch_r;
    logic                    write_r;
    logic [2:0]              funct3_r;
    logic [1:0]              addr_lo_r;

    logic                    sel_fetch_s;
    logic                    sel_write_s;
    logic [2:0]              sel_funct3_s;
    logic [1:0]              sel_addr_lo_s;
    logic                    legal_s;
    logic [3:0]              be_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic [DATA_WIDTH-1:0]   load_value_s;

    // Idle: judge the incoming request; otherwise decode the latched access for extension.
    always_comb begin
        sel_fetch_s   = fetch_r;
        sel_write_s   = write_r;
        sel_funct3_s  = funct3_r;
        sel_addr_lo_s = addr_lo_r;
        if (state_r == ST_IDLE) begin
            sel_fetch_s   = fetch;
            sel_write_s   = write;
            sel_funct3_s  = funct3;
            sel_addr_lo_s = address[1:0];
        end else begin
            sel_fetch_s   = fetch_r;
            sel_write_s   = write_r;
            sel_funct3_s  = funct3_r;
            sel_addr_lo_s = addr_lo_r;
        end
    end

    load_store_align u_align (
        .fetch      (sel_fetch_s),
        .write      (sel_write_s),
        .funct3     (sel_funct3_s),
        .addr_lo    (sel_addr_lo_s),
        .write_data (write_data),
        .mem_rdata  (mem.mem_rdata),
        .legal      (legal_s),
        .be         (be_s),
        .wdata      (wdata_s),
        .load_value (load_value_s)
    );

    // Access FSM with timeout counter and all architectural registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            instruction_r <= '0;
            old_pc_r      <= '0;
            read_data_r   <= '0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            mem_be_r      <= BE_NONE;
            cnt_r         <= '0;
            fetch_r       <= 1'b0;
            write_r       <= 1'b0;
            funct3_r      <= 3'b000;
            addr_lo_r     <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r    <= 1'b1;
                        fetch_r   <= fetch;
                        write_r   <= write;
                        funct3_r  <= funct3;
                        addr_lo_r <= address[1:0];
                        if (legal_s) begin
                            error_r     <= 1'b0;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= write & ~fetch;
                            mem_addr_r  <= {address[ADDR_WIDTH-1:2], 2'b00};
                            mem_be_r    <= be_s;
                            mem_wdata_r <= wdata_s;
                            cnt_r       <= '0;
                            if (fetch) begin
                                old_pc_r <= pc;
                            end else begin
                                old_pc_r <= old_pc_r;
                            end
                            state_r <= ST_ACCESS;
                        end else begin
                            error_r <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= ST_COMPLETE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // An ack on the timeout edge still completes normally.
                    if (mem_req_r && mem.mem_ack) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_COMPLETE;
                        if (fetch_r) begin
                            instruction_r <= mem.mem_rdata;
                        end else if (!write_r) begin
                            read_data_r <= load_value_s;
                        end else begin
                            read_data_r <= read_data_r;
                        end
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        error_r   <= 1'b1;
                        done_r    <= 1'b1;
                        state_r   <= ST_COMPLETE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_COMPLETE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign instruction   = instruction_r;
    assign old_pc        = old_pc_r;
    assign read_data     = read_data_r;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign mem.mem_be    = mem_be_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts every
// output each cycle; literal checks pin the model on the documented examples.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        fetch = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        busy, done, error;
    logic [31:0] instruction, old_pc, read_data;

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .fetch       (fetch),
        .write       (write),
        .funct3      (funct3),
        .address     (address),
        .write_data  (write_data),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .instruction (instruction),
        .old_pc      (old_pc),
        .read_data   (read_data),
        .mem         (mem_bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    logic        exp_busy = 0, exp_done = 0, exp_error = 0, exp_req = 0, exp_we = 0;
    logic [31:0] exp_instr = 0, exp_old_pc = 0, exp_read = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0;
    logic [3:0]  exp_be = 0;

    int          req_cycles = 0;
    logic [3:0]  seen_be = 0;
    logic [31:0] seen_wdata = 0;
    logic        seen_we = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_size(input bit f, input logic [2:0] f3);
        logic [1:0] lo;
        lo = f3[1:0];
        if (f) return 4;
        return 1 << lo;
    endfunction

    function automatic bit m_legal(input bit f, input bit w, input logic [2:0] f3, input logic [31:0] a);
        if (!f && w && f3 > 3'd2) return 1'b0;
        if (!f && !w && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        return (a % m_size(f, f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input bit f, input bit w, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        logic [1:0] lo;
        if (f || !w) return 4'hF;
        sz = m_size(f, f3);
        lo = a[1:0];
        return 4'(((1 << sz) - 1) << lo);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        sz = m_size(1'b0, f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        logic [1:0]  lo;
        lo = a[1:0];
        v  = rd >> (8 * lo);
        if (m_size(1'b0, f3) == 1) begin
            v = v & 32'hFF;
            if (f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
        end else if (m_size(1'b0, f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (checking) begin
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            chk("done", {31'b0, done}, {31'b0, exp_done});
            chk("error", {31'b0, error}, {31'b0, exp_error});
            chk("mem_req", {31'b0, mem_bus.mem_req}, {31'b0, exp_req});
            chk("instruction", instruction, exp_instr);
            chk("old_pc", old_pc, exp_old_pc);
            chk("read_data", read_data, exp_read);
            if (exp_req) begin
                chk("mem_we", {31'b0, mem_bus.mem_we}, {31'b0, exp_we});
                chk("mem_addr", mem_bus.mem_addr, exp_addr);
                chk("mem_be", {28'b0, mem_bus.mem_be}, {28'b0, exp_be});
                if (exp_we) chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
            end
        end
        if (mem_bus.mem_req) begin
            req_cycles = req_cycles + 1;
            seen_be    = mem_bus.mem_be;
            seen_wdata = mem_bus.mem_wdata;
            seen_we    = mem_bus.mem_we;
        end
    end

    // ack_after = 0 means memory never acknowledges.
    task automatic access(input bit f, input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] pcv,
                          input int ack_after, input logic [31:0] rd);
        req_cycles = 0;
        start = 1'b1; fetch = f; write = w; funct3 = f3; address = a; write_data = wd; pc = pcv;
        @(posedge clock); #1;
        start = 1'b0;
        exp_busy = 1'b1;
        if (!m_legal(f, w, f3, a)) begin
            exp_error = 1'b1;
            exp_done  = 1'b1;
        end else begin
            exp_error = 1'b0;
            exp_req   = 1'b1;
            exp_we    = w & ~f;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = m_be(f, w, f3, a);
            exp_wdata = m_wdata(f3, wd);
            if (f) exp_old_pc = pcv;
            for (int c = 1; c <= TO; c++) begin
                if (c == 1) begin
                    start = 1'b1;
                    address = 32'hFFFF_FFFF;
                end
                if (c == ack_after) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = rd;
                end
                @(posedge clock); #1;
                start = 1'b0;
                mem_bus.mem_ack = 1'b0;
                if (c == ack_after) begin
                    exp_req  = 1'b0;
                    exp_done = 1'b1;
                    if (f) exp_instr = rd;
                    else if (!w) exp_read = m_load(f3, a, rd);
                    break;
                end
                if (c == TO) begin
                    exp_req   = 1'b0;
                    exp_error = 1'b1;
                    exp_done  = 1'b1;
                end
            end
        end
        @(posedge clock); #1;
        exp_done = 1'b0;
        exp_busy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        @(posedge clock); #1;
        checking = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Fetch with 3-cycle latency
        access(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'h10, 3, 32'h0050_0093);
        chk("fetch_instr_lit", instruction, 32'h0050_0093);
        chk("fetch_oldpc_lit", old_pc, 32'h10);
        chk("fetch_req_cycles", 32'(req_cycles), 32'd3);
        chk("fetch_be_lit", {28'b0, seen_be}, 32'hF);
        chk("fetch_we_lit", {31'b0, seen_we}, 32'h0);

        // Loads with extension
        access(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 1, 32'h80FF_1234);
        chk("lb_lit", read_data, 32'hFFFF_FF80);
        access(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 2, 32'h80FF_1234);
        chk("lbu_lit", read_data, 32'h0000_0080);
        access(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0, 2, 32'h80FF_1234);
        chk("lh_lit", read_data, 32'hFFFF_80FF);
        chk("lh_instr_kept", instruction, 32'h0050_0093);

        // Stores
        access(1'b0, 1'b1, 3'b000, 32'h101, 32'hAB, 32'h0, 2, 32'h0);
        chk("sb_be_lit", {28'b0, seen_be}, 32'h2);
        chk("sb_wdata_lit", seen_wdata, 32'hABAB_ABAB);
        chk("sb_we_lit", {31'b0, seen_we}, 32'h1);
        access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234, 32'h0, 1, 32'h0);
        chk("sh_be_lit", {28'b0, seen_be}, 32'hC);
        chk("sh_wdata_lit", seen_wdata, 32'h1234_1234);

        // Misaligned lw, then a legal sw clears error
        access(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 32'h0);
        chk("lw_misaligned_err", {31'b0, error}, 32'h1);
        chk("lw_misaligned_noreq", 32'(req_cycles), 32'd0);
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 1, 32'h0);
        chk("sw_clears_err", {31'b0, error}, 32'h0);

        // Illegal funct3 and misaligned fetch
        access(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 32'h0);
        access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 32'h0);
        access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h44, 1, 32'h0);
        chk("bad_fetch_oldpc", old_pc, 32'h10);

        // Timeout
        access(1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 32'h0);
        chk("timeout_req_cycles", 32'(req_cycles), 32'd4);
        chk("timeout_err", {31'b0, error}, 32'h1);
        chk("timeout_read_kept", read_data, 32'hFFFF_80FF);

        // Stray ack while idle is ignored
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h5555_5555;
        @(posedge clock); #1;
        mem_bus.mem_ack = 1'b0;
        @(posedge clock); #1;

        // Reset in the middle of an access
        start = 1'b1; fetch = 1'b1; write = 1'b0; address = 32'h20; pc = 32'h20;
        @(posedge clock); #1;
        start = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h20; exp_be = 4'hF;
        exp_old_pc = 32'h20; exp_error = 1'b0;
        @(posedge clock); #1;
        #2;
        reset = 1'b1;
        exp_busy = 0; exp_done = 0; exp_error = 0; exp_req = 0;
        exp_instr = 0; exp_old_pc = 0; exp_read = 0;
        #1;
        chk("rst_mem_req", {31'b0, mem_bus.mem_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_old_pc", old_pc, 32'h0);
        chk("rst_read", read_data, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        access(1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 32'h0, 1, 32'h80FF_1234);
        chk("lhu_after_rst_lit", read_data, 32'h0000_80FF);

        @(posedge clock); #1;
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
